// File: rtl/bf16_div_retire_if.sv
// Handshake bundle between the bfloat16 divider, the retire stage and its consumer.
//   in_*  : divider -> retire stage. Carries the quotient {sign, exp, sig}, the one-hot
//           class flags and the exception vector, with a valid/ready handshake.
//   out_* : retire stage -> consumer. Carries the head FIFO entry, with a valid/ready
//           handshake.
// The slave modport is the retire stage's view. The master modport is the view of the
// environment that drives the divider side and the consumer side.
interface bf16_div_retire_if #(
  parameter int NEXP = 8,
  parameter int NSIG = 7
);
  localparam int QW = NEXP + NSIG + 1;

  logic          in_valid;
  logic          in_ready;
  logic [QW-1:0] in_q;
  logic [5:0]    in_flags;
  logic [4:0]    in_exc;

  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_q;
  logic [5:0]    out_flags;
  logic [4:0]    out_exc;

  modport slave (
    input  in_valid, in_q, in_flags, in_exc, out_ready,
    output in_ready, out_valid, out_q, out_flags, out_exc
  );

  modport master (
    output in_valid, in_q, in_flags, in_exc, out_ready,
    input  in_ready, out_valid, out_q, out_flags, out_exc
  );
endinterface

// File: rtl/bf16_div_retire.sv
// Retire stage for the bfloat16 divider.
// Each accepted quotient is buffered in a DEPTH-entry FIFO and presented to the
// consumer in order. NaN quotients are canonicalised when they are written.
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   bus (slave)  : in_* divider handshake and out_* consumer handshake
//   fflags_clr   : clear pulse for fflags, trap and proto_err
//   trap_en      : per-bit trap enable for the exception flags
//   fflags       : sticky OR of the exception vectors of accepted results
//   trap         : registered |(fflags & trap_en)
//   proto_err    : sticky; an accepted class vector was not exactly one-hot
//   level        : current FIFO occupancy
//   retired_cnt  : saturating count of popped results
module bf16_div_retire #(
  parameter int NEXP  = 8,
  parameter int NSIG  = 7,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bf16_div_retire_if.slave        bus,
  input  logic                    fflags_clr,
  input  logic [4:0]              trap_en,
  output logic [4:0]              fflags,
  output logic                    trap,
  output logic                    proto_err,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNTW-1:0]         retired_cnt
);
  localparam int QW = NEXP + NSIG + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Canonical quiet NaN: positive, all-ones exponent, quiet bit only (0x7FC0 for bf16).
  localparam logic [QW-1:0] CANON_NAN = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

  typedef struct packed {
    logic [QW-1:0] q;
    logic [5:0]    flags;
    logic [4:0]    exc;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [4:0]      fflags_q, fflags_d;
  logic            trap_q, trap_d;
  logic            proto_err_q, proto_err_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic   can_accept, has_head, push, pop;
  logic   is_nan, one_hot;
  entry_t wr_entry, head;

  always_comb begin
    // NOTE: every signal gets a default first so that no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    cnt_d       = cnt_q;

    // Readiness depends only on the registered occupancy. A full FIFO therefore refuses
    // a push even when the consumer pops in the same cycle.
    can_accept  = (level_q < LW'(DEPTH));
    has_head    = (level_q != '0);
    push        = bus.in_valid & can_accept;
    pop         = has_head & bus.out_ready;

    is_nan      = bus.in_flags[4] | bus.in_flags[5];
    one_hot     = (bus.in_flags != '0) && ((bus.in_flags & (bus.in_flags - 6'd1)) == '0);

    wr_entry.q     = is_nan ? CANON_NAN : bus.in_q;
    wr_entry.flags = is_nan ? 6'b010000 : bus.in_flags;
    wr_entry.exc   = bus.in_exc | (bus.in_flags[5] ? 5'b10000 : 5'b00000);

    if (push) begin
      mem_d[wr_ptr_q] = wr_entry;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    // A newly accepted exception bit or protocol error wins over a clear in the same cycle.
    fflags_d    = (fflags_clr ? 5'b00000 : fflags_q) | (push ? wr_entry.exc : 5'b00000);
    trap_d      = |(fflags_d & trap_en);
    proto_err_d = (fflags_clr ? 1'b0 : proto_err_q) | (push & ~one_hot);

    head = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset as well. It is only DEPTH entries, and the
      // reset makes out_q/out_flags/out_exc read as zero while the FIFO is empty after reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      fflags_q    <= '0;
      trap_q      <= 1'b0;
      proto_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every flop samples
      // values from before the edge regardless of statement order.
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      fflags_q    <= fflags_d;
      trap_q      <= trap_d;
      proto_err_q <= proto_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = can_accept;
  assign bus.out_valid = has_head;
  assign bus.out_q     = head.q;
  assign bus.out_flags = head.flags;
  assign bus.out_exc   = head.exc;
  assign fflags        = fflags_q;
  assign trap          = trap_q;
  assign proto_err     = proto_err_q;
  assign level         = level_q;
  assign retired_cnt   = cnt_q;
endmodule

// File: tb/tb_bf16_div_retire.sv
// Testbench for bf16_div_retire.
// A queue-based reference model follows the DUT through directed scenarios and
// randomized traffic. A compare process checks every DUT output against the model on
// each falling clock edge. Literal expectations in the directed scenarios pin the model.
module tb_bf16_div_retire;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fflags_clr;
  logic [4:0]  trap_en;
  logic [4:0]  fflags;
  logic        trap;
  logic        proto_err;
  logic [2:0]  level;
  logic [15:0] retired_cnt;

  int total = 0;
  int bad   = 0;

  bf16_div_retire_if #(.NEXP(8), .NSIG(7)) bus ();

  bf16_div_retire #(.NEXP(8), .NSIG(7), .DEPTH(DEPTH), .CNTW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .fflags_clr  (fflags_clr),
    .trap_en     (trap_en),
    .fflags      (fflags),
    .trap        (trap),
    .proto_err   (proto_err),
    .level       (level),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] q;
    logic [5:0]  flags;
    logic [4:0]  exc;
  } ent_t;

  ent_t        mq[$];
  logic [4:0]  m_fflags = '0;
  bit          m_trap = 1'b0;
  bit          m_proto = 1'b0;
  int unsigned m_cnt = 0;

  function automatic ent_t store_form(logic [15:0] q, logic [5:0] flags, logic [4:0] exc);
    ent_t e;
    e.q = q; e.flags = flags; e.exc = exc;
    if (flags[4] || flags[5]) begin
      e.q     = 16'h7FC0;
      e.flags = 6'b010000;
    end
    if (flags[5]) e.exc = exc | 5'b10000;
    return e;
  endfunction

  always @(negedge rst_n) begin
    mq.delete();
    m_fflags = '0;
    m_trap   = 1'b0;
    m_proto  = 1'b0;
    m_cnt    = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit   m_push, m_pop;
      ent_t e;
      m_push = bus.in_valid && (mq.size() < DEPTH);
      m_pop  = (mq.size() != 0) && bus.out_ready;
      e = store_form(bus.in_q, bus.in_flags, bus.in_exc);
      m_fflags = (fflags_clr ? 5'b0 : m_fflags) | (m_push ? e.exc : 5'b0);
      m_trap   = |(m_fflags & trap_en);
      m_proto  = (fflags_clr ? 1'b0 : m_proto) | (m_push && ($countones(bus.in_flags) != 1));
      if (m_pop) begin
        void'(mq.pop_front());
        if (m_cnt != 32'h0000_FFFF) m_cnt++;
      end
      if (m_push) mq.push_back(e);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready",    32'(bus.in_ready),  32'(mq.size() < DEPTH));
      check("out_valid",   32'(bus.out_valid), 32'(mq.size() != 0));
      check("level",       32'(level),         32'(mq.size()));
      check("fflags",      32'(fflags),        32'(m_fflags));
      check("trap",        32'(trap),          32'(m_trap));
      check("proto_err",   32'(proto_err),     32'(m_proto));
      check("retired_cnt", 32'(retired_cnt),   m_cnt);
      if (mq.size() != 0) begin
        check("out_q",     32'(bus.out_q),     32'(mq[0].q));
        check("out_flags", 32'(bus.out_flags), 32'(mq[0].flags));
        check("out_exc",   32'(bus.out_exc),   32'(mq[0].exc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] q, input logic [5:0] f, input logic [4:0] x);
    bus.in_valid = v;
    bus.in_q     = q;
    bus.in_flags = f;
    bus.in_exc   = x;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] vals [5];
    int          got;
    bit          will_push;

    set_in(1'b0, 16'h0, 6'h0, 5'h0);
    bus.out_ready = 1'b0;
    fflags_clr    = 1'b0;
    trap_en       = 5'b0;
    do_reset();

    // Reset state.
    check("rst_level",     32'(level),         32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_q",     32'(bus.out_q),     32'd0);
    check("rst_fflags",    32'(fflags),        32'd0);
    check("rst_cnt",       32'(retired_cnt),   32'd0);

    // 1: single result, one-cycle latency.
    bus.out_ready = 1'b1;
    set_in(1'b1, 16'h3F00, 6'b000001, 5'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_out_q",     32'(bus.out_q),     32'h3F00);
    tick();
    check("t1_cnt",    32'(retired_cnt), 32'd1);
    check("t1_fflags", 32'(fflags),      32'd0);
    check("t1_trap",   32'(trap),        32'd0);

    // 2: fill to full, hold off the fifth, then drain in order.
    do_reset();
    bus.out_ready = 1'b0;
    vals[0] = 16'h4000; vals[1] = 16'h3F80; vals[2] = 16'hBF80; vals[3] = 16'h3F99; vals[4] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, vals[i], 6'b000001, 5'b0);
      tick();
    end
    set_in(1'b1, vals[4], 6'b000100, 5'b0);
    check("t2_full_ready", 32'(bus.in_ready), 32'd0);
    check("t2_full_level", 32'(level),        32'd4);
    repeat (2) tick();
    check("t2_hold_level", 32'(level),     32'd4);
    check("t2_hold_head",  32'(bus.out_q), 32'h4000);
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      will_push = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        check("t2_drain_q", 32'(bus.out_q), 32'(vals[got]));
        got++;
      end
      tick();
      if (will_push) bus.in_valid = 1'b0;
    end
    check("t2_drain_count", 32'(got),         32'd5);
    check("t2_cnt",         32'(retired_cnt), 32'd5);

    // 3: sNaN is canonicalised and raises invalid, which traps.
    trap_en = 5'b10000;
    set_in(1'b1, 16'h7FA1, 6'b100000, 5'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t3_out_q",     32'(bus.out_q),     32'h7FC0);
    check("t3_out_flags", 32'(bus.out_flags), 32'b010000);
    check("t3_out_exc",   32'(bus.out_exc),   32'b10000);
    check("t3_fflags",    32'(fflags),        32'b10000);
    check("t3_trap",      32'(trap),          32'd1);
    tick();

    // 4: new exception bit wins over a simultaneous clear.
    set_in(1'b1, 16'h7F80, 6'b001000, 5'b01000);
    fflags_clr = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    fflags_clr   = 1'b0;
    check("t4_fflags", 32'(fflags), 32'b01000);
    check("t4_trap",   32'(trap),   32'd0);
    tick();

    // 5: a class vector that is not one-hot sets proto_err; the entry is still stored.
    set_in(1'b1, 16'h1234, 6'b000011, 5'b0);
    tick();
    bus.in_valid = 1'b0;
    check("t5_proto",   32'(proto_err),     32'd1);
    check("t5_stored",  32'(bus.out_q),     32'h1234);
    check("t5_sflags",  32'(bus.out_flags), 32'b000011);
    tick();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    check("t5_proto_clr", 32'(proto_err), 32'd0);

    // 6: asynchronous reset mid-cycle with three entries buffered.
    bus.out_ready = 1'b0;
    fflags_clr    = 1'b1;
    set_in(1'b1, 16'h3F80, 6'b000001, 5'b00001);
    tick();
    fflags_clr = 1'b0;
    set_in(1'b1, 16'h4040, 6'b000001, 5'b00100);
    tick();
    set_in(1'b1, 16'h0000, 6'b000100, 5'b00000);
    tick();
    bus.in_valid = 1'b0;
    check("t6_pre_level",  32'(level),  32'd3);
    check("t6_pre_fflags", 32'(fflags), 32'b00101);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_level",     32'(level),         32'd0);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_fflags",    32'(fflags),        32'd0);
    check("t6_cnt",       32'(retired_cnt),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic checked by the compare process against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      bus.in_valid  = ($urandom_range(0, 9) < 6);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.in_q      = 16'($urandom);
      if ($urandom_range(0, 9) == 0) bus.in_flags = 6'($urandom);
      else                          bus.in_flags = 6'b000001 << $urandom_range(0, 5);
      bus.in_exc    = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      fflags_clr    = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) trap_en = 5'($urandom);
      tick();
    end
    bus.in_valid = 1'b0;
    fflags_clr   = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bf16_div_retire.md
Name: bf16_div_retire

Overview:
- Downstream retire stage for the bfloat16 divider (hp_div, NEXP=8, NSIG=7).
- Accepts each quotient with its class flags (bfFlags) and exception vector through a valid/ready handshake, buffers results in a small FIFO, and presents them to the consumer in order.
- Canonicalises NaN quotients.
- Maintains sticky IEEE exception flags, a trap output, a protocol-error flag and a retired-result counter.

Parameters:
- NEXP, 8, exponent width.
- NSIG, 7, stored significand width.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNTW, 16, width of retired-result counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  divider result valid.
- in_ready  out  1  stage can accept.
- in_q  in  NEXP+NSIG+1  quotient {sign, exp, sig}.
- in_flags  in  6  class one-hot: [0] normal, [1] subnormal, [2] zero, [3] infinity, [4] qNaN, [5] sNaN.
- in_exc  in  5  [4] invalid, [3] divide-by-zero, [2] overflow, [1] underflow, [0] inexact.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_q  out  NEXP+NSIG+1  head quotient.
- out_flags  out  6  head class.
- out_exc  out  5  head exceptions.
- fflags  out  5  sticky OR of accepted in_exc.
- fflags_clr  in  1  clear pulse for fflags, trap and proto_err.
- trap_en  in  5  per-bit trap enable.
- trap  out  1  registered; high when (fflags & trap_en) != 0.
- proto_err  out  1  sticky; set when an accepted in_flags is not exactly one-hot.
- level  out  clog2(DEPTH)+1  current occupancy.
- retired_cnt  out  CNTW  results popped, saturating.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, rd/wr pointers 0, level=0, out_valid=0, out_q/out_flags/out_exc=0, fflags=0, trap=0, proto_err=0, retired_cnt=0. Release takes effect on the next edge. Reset mid-stream discards all buffered entries.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (level < DEPTH), taken from registered level only. There is no combinational path from out_ready, so a full FIFO refuses a push even when a pop occurs in the same cycle.
  - out_valid = (level != 0).
  - out_* are driven from the head entry. The head holds stable while out_valid & !out_ready.
- Latency: an entry pushed at edge N is visible on out_* after edge N when the FIFO was empty. There is no bypass.
- Simultaneous push and pop: level unchanged; both pointers advance and wrap modulo DEPTH.
- Push while full (in_valid=1, in_ready=0): ignored. No sticky-flag updates.
- Pop while empty: impossible, because out_valid=0.
- NaN canonicalisation on push when in_flags[4] or in_flags[5] is set:
  - stored q = {1'b0, all-ones exp, 1'b1, zeros}; for bf16 this is 0x7FC0.
  - stored flags = 6'b010000.
  - If in_flags[5] (sNaN), stored exc = in_exc | 5'b10000.
  - Otherwise the fields are stored unmodified.
- fflags_next = (fflags_clr ? 0 : fflags) | (push ? stored_exc : 0). Newly accepted bits win over a clear in the same cycle.
- trap <= |(fflags_next & trap_en).
- proto_err <= (fflags_clr ? 0 : proto_err) | (push & in_flags not one-hot). A set in the same cycle wins over a clear.
- retired_cnt increments on each pop and holds at all-ones.

Test Plan:
1. Reset, then push q=0x3F00, flags=6'b000001, exc=0 with out_ready=1 → out_valid rises one cycle later with out_q=0x3F00; retired_cnt=1; fflags=0; trap=0.
2. out_ready=0; push 5 results (0x4000, 0x3F80, 0xBF80, 0x3F99, 0x0000) back to back → first 4 accepted; in_ready=0 while level=4; 5th is held by its source. Raise out_ready → results drain in order 0x4000, 0x3F80, 0xBF80, 0x3F99, then 0x0000 after re-push; retired_cnt=5.
3. Push q=0x7FA1, flags=6'b100000 (sNaN), exc=0 → out_q=0x7FC0, out_flags=6'b010000, out_exc=5'b10000, fflags=5'b10000. With trap_en=5'b10000, trap=1 one cycle after the push.
4. Push exc=5'b01000 (1.0÷0 → 0x7F80, flags=6'b001000) in the same cycle as fflags_clr=1 while fflags=5'b10000 → fflags=5'b01000. With trap_en=5'b10000, trap=0.
5. Push flags=6'b000011 → proto_err=1 and the entry is still stored. A later fflags_clr with no push clears proto_err.
6. Assert rst_n=0 asynchronously with level=3 and fflags=5'b00101, mid-clock → level=0, out_valid=0, fflags=0, retired_cnt=0 immediately, before the next edge.
